xadac_axi_ctrl: RTL and testbench

Outstanding-transaction controller between the xadac memory units (vload reads, vactv writes) and the shared AXI master port. It gates AR/AW handshakes using a read credit counter and a write-tracking table, and consumes B responses. It also enforces read-after-write ordering at vector-line granularity, so a load never overtakes an in-flight store to the same line. Instantiated in xadac between the units and the AXI assigns; W and R data pass outside it.

---
 rtl/xadac_axi_ctrl_if.sv | 29 ++
 rtl/xadac_axi_ctrl.sv | 126 ++++++++++++
 tb/tb_xadac_axi_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/xadac_axi_ctrl_if.sv
// xadac_axi_ctrl_if: unit-side request, AXI-side AR/AW and B/R status signals of the AXI controller
interface xadac_axi_ctrl_if #(
   parameter int IdWidth   = 4,
   parameter int AddrWidth = 64
);
   logic [IdWidth-1:0]   ar_id_i, ar_id_o, aw_id_i, aw_id_o, b_id_i;
   logic [AddrWidth-1:0] ar_addr_i, ar_addr_o, aw_addr_i, aw_addr_o;
   logic                 ar_valid_i, ar_ready_o, ar_valid_o, ar_ready_i;
   logic                 aw_valid_i, aw_ready_o, aw_valid_o, aw_ready_i;
   logic                 r_fire_i, b_valid_i, b_ready_o;

   modport slave (
      input  ar_id_i, ar_addr_i, ar_valid_i, ar_ready_i,
      input  aw_id_i, aw_addr_i, aw_valid_i, aw_ready_i,
      input  r_fire_i, b_id_i, b_valid_i,
      output ar_id_o, ar_addr_o, ar_valid_o, ar_ready_o,
      output aw_id_o, aw_addr_o, aw_valid_o, aw_ready_o,
      output b_ready_o
   );

   modport master (
      output ar_id_i, ar_addr_i, ar_valid_i, ar_ready_i,
      output aw_id_i, aw_addr_i, aw_valid_i, aw_ready_i,
      output r_fire_i, b_id_i, b_valid_i,
      input  ar_id_o, ar_addr_o, ar_valid_o, ar_ready_o,
      input  aw_id_o, aw_addr_o, aw_valid_o, aw_ready_o,
      input  b_ready_o
   );
endinterface

// File: rtl/xadac_axi_ctrl.sv
// xadac_axi_ctrl: read credits, write-tracking table and line-granular RAW ordering for the AXI port.
// Optional stall counters enabled by defining XADAC_AXI_CTRL_PERF_EN.
module xadac_axi_ctrl #(
   parameter int IdWidth   = 4,
   parameter int AddrWidth = 64,
   parameter int OffBits   = 4,
   parameter int NoRd      = 8,
   parameter int NoWr      = 4
) (
   input  logic                clk,
   input  logic                rstn,
   xadac_axi_ctrl_if.slave     bus,
   output logic [7:0]          rd_cnt_o,
   output logic [4:0]          wr_cnt_o,
   output logic                idle_o,
   output logic                err_o,
   output logic [31:0]         perf_raw_o,
   output logic [31:0]         perf_crd_o
);
   localparam int LW = AddrWidth - OffBits;
   localparam int IW = NoWr > 1 ? $clog2(NoWr) : 1;

   logic [7:0]         rd_cnt_q, rd_cnt_d;
   logic [NoWr-1:0]    vld_q, vld_d, b_clr;
   logic [IdWidth-1:0] id_q [NoWr];
   logic [LW-1:0]      line_q [NoWr];
   logic               err_q, err_d;
   logic               raw, rd_full, rd_stall, ar_fire, wr_full, id_hit, wr_stall, aw_fire, r_under;
   logic [IW-1:0]      free_idx;
   logic [4:0]         pop;

   // All lookups use registered table state only; same-cycle frees and allocations are invisible
   always_comb begin
      raw      = 1'b0;
      id_hit   = 1'b0;
      b_clr    = '0;
      free_idx = '0;
      pop      = '0;
      for (int i = NoWr - 1; i >= 0; i--) begin
         raw      |= vld_q[i] & (line_q[i] == bus.ar_addr_i[AddrWidth-1:OffBits]);
         id_hit   |= vld_q[i] & (id_q[i] == bus.aw_id_i);
         b_clr[i]  = vld_q[i] & bus.b_valid_i & (id_q[i] == bus.b_id_i);
         pop      += 5'(vld_q[i]);
         free_idx  = vld_q[i] ? free_idx : IW'(i);
      end
   end

   assign rd_full  = rd_cnt_q == 8'(NoRd);
   assign rd_stall = rd_full | raw;
   assign wr_full  = &vld_q;
   assign wr_stall = wr_full | id_hit;
   assign ar_fire  = bus.ar_valid_o & bus.ar_ready_i;
   assign aw_fire  = bus.aw_valid_o & bus.aw_ready_i;
   assign r_under  = bus.r_fire_i & ~ar_fire & (rd_cnt_q == 8'd0);

   assign bus.ar_id_o    = bus.ar_id_i;
   assign bus.ar_addr_o  = bus.ar_addr_i;
   assign bus.ar_valid_o = bus.ar_valid_i & ~rd_stall;
   assign bus.ar_ready_o = bus.ar_ready_i & ~rd_stall;
   assign bus.aw_id_o    = bus.aw_id_i;
   assign bus.aw_addr_o  = bus.aw_addr_i;
   assign bus.aw_valid_o = bus.aw_valid_i & ~wr_stall;
   assign bus.aw_ready_o = bus.aw_ready_i & ~wr_stall;
   assign bus.b_ready_o  = 1'b1;

   always_comb begin
      rd_cnt_d = (ar_fire & ~bus.r_fire_i) ? rd_cnt_q + 8'd1 :
                 (~ar_fire & bus.r_fire_i & ~r_under) ? rd_cnt_q - 8'd1 : rd_cnt_q;
      err_d    = err_q | r_under | (bus.b_valid_i & ~|b_clr);
      vld_d    = vld_q & ~b_clr;
      if (aw_fire) vld_d[free_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_cnt_q <= '0;
         vld_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         rd_cnt_q <= rd_cnt_d;
         vld_q    <= vld_d;
         err_q    <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (aw_fire) begin
         id_q[free_idx]   <= bus.aw_id_i;
         line_q[free_idx] <= bus.aw_addr_i[AddrWidth-1:OffBits];
      end
   end

   assign rd_cnt_o = rd_cnt_q;
   assign wr_cnt_o = pop;
   assign idle_o   = (rd_cnt_q == 8'd0) & (pop == 5'd0);
   assign err_o    = err_q;

`ifdef XADAC_AXI_CTRL_PERF_EN
   logic [31:0] perf_raw_q, perf_raw_d, perf_crd_q, perf_crd_d;
   logic        raw_blk, crd_blk;

   assign raw_blk = bus.ar_valid_i & raw;
   assign crd_blk = (bus.ar_valid_i & rd_full) | (bus.aw_valid_i & wr_full);

   always_comb begin
      perf_raw_d = perf_raw_q + 32'(raw_blk & ~&perf_raw_q);
      perf_crd_d = perf_crd_q + 32'(crd_blk & ~&perf_crd_q);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         perf_raw_q <= '0;
         perf_crd_q <= '0;
      end else begin
         perf_raw_q <= perf_raw_d;
         perf_crd_q <= perf_crd_d;
      end
   end

   assign perf_raw_o = perf_raw_q;
   assign perf_crd_o = perf_crd_q;
`else
   assign perf_raw_o = '0;
   assign perf_crd_o = '0;
`endif
endmodule

// File: tb/tb_xadac_axi_ctrl.sv
// tb_xadac_axi_ctrl: directed and random traffic against a transaction-level model of credits,
// outstanding-write set, RAW line ordering, sticky error and perf counters.
module tb_xadac_axi_ctrl;
   localparam int NoRd = 8;
   localparam int NoWr = 4;

   typedef struct {
      logic [3:0]  id;
      logic [59:0] line;
   } wr_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [7:0]  rd_cnt;
   logic [4:0]  wr_cnt;
   logic        idle, err;
   logic [31:0] perf_raw, perf_crd;

   xadac_axi_ctrl_if #(.IdWidth(4), .AddrWidth(64)) bus ();

   xadac_axi_ctrl #(.IdWidth(4), .AddrWidth(64), .OffBits(4), .NoRd(NoRd), .NoWr(NoWr)) dut (
      .clk(clk), .rstn(rstn), .bus(bus),
      .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt), .idle_o(idle), .err_o(err),
      .perf_raw_o(perf_raw), .perf_crd_o(perf_crd)
   );

   always #5 clk = ~clk;

   int      total = 0, passed = 0;
   int      mrd = 0;
   bit      merr = 1'b0;
   longint  praw = 0, pcrd = 0;
   wr_t     wq[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic idle_inputs();
      bus.ar_valid_i = 0; bus.ar_ready_i = 0; bus.ar_id_i = 0; bus.ar_addr_i = 0;
      bus.aw_valid_i = 0; bus.aw_ready_i = 0; bus.aw_id_i = 0; bus.aw_addr_i = 0;
      bus.r_fire_i = 0; bus.b_valid_i = 0; bus.b_id_i = 0;
   endtask

   task automatic chk_state(input string pfx);
      chk({pfx, "rd_cnt"}, rd_cnt, mrd);
      chk({pfx, "wr_cnt"}, wr_cnt, wq.size());
      chk({pfx, "idle"}, idle, (mrd == 0) && (wq.size() == 0));
      chk({pfx, "err"}, err, merr);
`ifdef XADAC_AXI_CTRL_PERF_EN
      chk({pfx, "perf_raw"}, perf_raw, praw);
      chk({pfx, "perf_crd"}, perf_crd, pcrd);
`else
      chk({pfx, "perf_raw"}, perf_raw, 0);
      chk({pfx, "perf_crd"}, perf_crd, 0);
`endif
   endtask

   // One clock cycle: drive at negedge, check before posedge, advance the model at posedge
   task automatic cyc(input bit arv, input logic [63:0] araddr, input bit arrdy,
                      input bit awv, input logic [3:0] awid, input logic [63:0] awaddr, input bit awrdy,
                      input bit rf, input bit bv, input logic [3:0] bid);
      bit raw, rst, idh, wst, arf, awf, found;
      logic [63:0] a;
      @(negedge clk);
      bus.ar_valid_i = arv; bus.ar_addr_i = araddr; bus.ar_ready_i = arrdy; bus.ar_id_i = 4'($urandom);
      bus.aw_valid_i = awv; bus.aw_id_i = awid; bus.aw_addr_i = awaddr; bus.aw_ready_i = awrdy;
      bus.r_fire_i = rf; bus.b_valid_i = bv; bus.b_id_i = bid;
      #1;
      a = araddr;
      raw = 0; idh = 0;
      foreach (wq[i]) begin
         if (wq[i].line == a[63:4]) raw = 1;
         if (wq[i].id == awid) idh = 1;
      end
      rst = (mrd == NoRd) || raw;
      wst = (wq.size() == NoWr) || idh;
      chk("ar_valid_o", bus.ar_valid_o, arv && !rst);
      chk("ar_ready_o", bus.ar_ready_o, arrdy && !rst);
      chk("aw_valid_o", bus.aw_valid_o, awv && !wst);
      chk("aw_ready_o", bus.aw_ready_o, awrdy && !wst);
      chk("ar_addr_o", bus.ar_addr_o, araddr);
      chk("ar_id_o", bus.ar_id_o, bus.ar_id_i);
      chk("aw_id_o", bus.aw_id_o, awid);
      chk("aw_addr_o", bus.aw_addr_o, awaddr);
      chk("b_ready_o", bus.b_ready_o, 1);
      chk_state("");
      if (arv && raw && praw < 64'hFFFF_FFFF) praw++;
      if (((arv && mrd == NoRd) || (awv && wq.size() == NoWr)) && pcrd < 64'hFFFF_FFFF) pcrd++;
      arf = arv && !rst && arrdy;
      awf = awv && !wst && awrdy;
      @(posedge clk);
      if (arf && !rf) mrd++;
      else if (!arf && rf) begin
         if (mrd == 0) merr = 1; else mrd--;
      end
      if (bv) begin
         found = 0;
         foreach (wq[i]) if (!found && wq[i].id == bid) begin wq.delete(i); found = 1; end
         if (!found) merr = 1;
      end
      if (awf) wq.push_back('{id: awid, line: awaddr[63:4]});
   endtask

   task automatic rd(input logic [63:0] a, input bit rf = 0);
      cyc(1, a, 1, 0, 0, 0, 0, rf, 0, 0);
   endtask

   task automatic wr(input logic [3:0] id, input logic [63:0] a, input bit bv = 0, input logic [3:0] bid = 0);
      cyc(0, 0, 0, 1, id, a, 1, 0, bv, bid);
   endtask

   task automatic resp(input bit rf, input bit bv, input logic [3:0] bid);
      cyc(0, 0, 0, 0, 0, 0, 0, rf, bv, bid);
   endtask

   task automatic async_reset();
      #2 rstn = 0;
      #1;
      mrd = 0; merr = 0; praw = 0; pcrd = 0; wq.delete();
      chk_state("rst_");
      idle_inputs();
      @(negedge clk);
      rstn = 1;
   endtask

   initial begin
      logic [63:0] ra, wa;
      bit rf, bv;
      logic [3:0] bid;
      idle_inputs();
      #12;
      chk_state("reset_");
      @(negedge clk);
      rstn = 1;

      // read credit limit
      for (int i = 0; i < 8; i++) rd(64'h8000 + 64'(i) * 64'h40);
      rd(64'h9000);
      rd(64'h9000, 1);
      rd(64'h9000);
      cyc(1, 64'hA000, 1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) resp(1, 0, 0);
      rd(64'hB000);
      rd(64'hB040, 1);
      resp(1, 0, 0);

      // RAW hazard
      wr(2, 64'h1000);
      rd(64'h100C);
      rd(64'h1010);
      cyc(1, 64'h100C, 1, 0, 0, 0, 0, 0, 1, 2);
      rd(64'h100C);
      resp(1, 0, 0);
      resp(1, 0, 0);

      // same-line AR and AW in one cycle: read goes first
      cyc(1, 64'h3008, 1, 1, 9, 64'h3000, 1, 0, 0, 0);
      rd(64'h3004);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 9);

      // duplicate ID and table full
      wr(3, 64'h4000);
      wr(3, 64'h5000);
      wr(3, 64'h5000);
      wr(3, 64'h5000, 1, 3);
      wr(3, 64'h5000);
      wr(4, 64'h6000);
      wr(5, 64'h7000);
      wr(6, 64'h7100);
      wr(7, 64'h7200);
      wr(7, 64'h7200);
      resp(0, 1, 3);
      wr(1, 64'h7300, 1, 4);
      wr(0, 64'h7400);
      for (int i = 0; i < 4; i++) resp(0, 1, 4'(i) + 4'(i > 0 ? 4 : 0));

      // errors and async reset
      resp(0, 1, 7);
      resp(0, 0, 0);
      rd(64'hC000);
      wr(2, 64'hD000);
      async_reset();
      resp(1, 0, 0);
      resp(0, 0, 0);
      async_reset();

      // RAW-blocked read held for five cycles
      wr(2, 64'h2000);
      for (int i = 0; i < 5; i++) rd(64'h2004);
      resp(0, 1, 2);
      rd(64'h2004);
      resp(1, 0, 0);
      resp(0, 0, 0);
      async_reset();

      // random traffic
      for (int n = 0; n < 600; n++) begin
         ra = 64'(($urandom_range(0, 7) << 4) | $urandom_range(0, 15));
         wa = 64'(($urandom_range(0, 7) << 4) | $urandom_range(0, 15));
         rf = mrd > 0 ? bit'($urandom_range(0, 2) == 0) : bit'($urandom_range(0, 40) == 0);
         bv = 0; bid = 0;
         if (wq.size() > 0 && $urandom_range(0, 2) == 0) begin
            bv = 1; bid = wq[$urandom_range(0, wq.size() - 1)].id;
         end else if ($urandom_range(0, 50) == 0) begin
            bv = 1; bid = 4'($urandom);
         end
         cyc(bit'($urandom), ra, bit'($urandom), bit'($urandom), 4'($urandom_range(0, 5)), wa,
             bit'($urandom), rf, bv, bid);
         if (n == 300) async_reset();
      end
      resp(0, 0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
